// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// PARITY is only reachable when the block is built with PARITY_EN defined.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        STOP,
        PARITY
    } state_t;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: tick pulses on the last cycle of each CLKS_PER_BIT window.
// Latency: tick is combinational from the count register. Backpressure: none; clear restarts the window.
// Clear forces the next cycle to be count 0, so a new state always begins a full bit.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a 4-deep FIFO and sends each as an 8N1 frame, LSB first (8E1 when PARITY_EN is defined).
// Latency: START begins 3 cycles after a non-empty FIFO is seen in IDLE; frames are 10 (11) bit periods.
// Backpressure: one pop per frame, re-issued while a FIFO push collides; fifo_empty sampled only in IDLE / end of STOP.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    input  logic       fifo_push,
    output logic       fifo_pop,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int                 BW       = $clog2(DATA_BITS);
    localparam logic [BW-1:0]      LAST_BIT = BW'(DATA_BITS - 1);

    state_t                 state;
    state_t                 state_next;
    logic [DATA_BITS-1:0]   shift;
    logic [BW-1:0]          bit_idx;
    logic                   tick;
    logic                   baud_clear;
    logic                   tx_next;
`ifdef PARITY_EN
    logic                   parity;
`endif

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .reset(reset),
        .clear(baud_clear),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (!fifo_empty) state_next = POP;
            // A simultaneous push wins inside the FIFO, so the pop must be repeated.
            POP:   if (!fifo_push) state_next = LOAD;
            LOAD:  state_next = START;
            START: if (tick) state_next = DATA;
            DATA: begin
                if (tick && bit_idx == LAST_BIT) begin
`ifdef PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef PARITY_EN
            PARITY: if (tick) state_next = STOP;
`endif
            STOP:  if (tick) state_next = fifo_empty ? IDLE : POP;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        fifo_pop   = (state == POP) && !reset;
        busy       = (state != IDLE);
        frame_done = (state == STOP) && tick;
        baud_clear = (state_next != state) || (state == IDLE) || (state == POP) || (state == LOAD);
        // tx is registered from the upcoming state so it lines up with the state it belongs to.
        case (state_next)
            START:   tx_next = ~IDLE_LEVEL;
            DATA:    tx_next = (state == DATA && tick) ? shift[1] : shift[0];
`ifdef PARITY_EN
            PARITY:  tx_next = parity;
`endif
            default: tx_next = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift   <= '0;
            bit_idx <= '0;
            tx      <= IDLE_LEVEL;
`ifdef PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            if (state == LOAD) begin
                shift   <= fifo_data;
                bit_idx <= '0;
`ifdef PARITY_EN
                parity  <= ^fifo_data;
`endif
            end else if (state == DATA && tick) begin
                shift   <= {1'b0, shift[DATA_BITS-1:1]};
                bit_idx <= bit_idx + 1'b1;
            end
            tx <= tx_next;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a FIFO model feeds bytes, a UART line decoder checks each frame against a scoreboard.
// Directed cases (idle, 0xA5, back-to-back, push collision, mid-frame reset) are followed by random traffic.
module tb_fifo_uart_tx;

    localparam int N = 4;
`ifdef PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_push;
    logic       fifo_pop;
    logic       tx;
    logic       busy;
    logic       frame_done;

    fifo_uart_tx #(.CLKS_PER_BIT(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_push (fifo_push),
        .fifo_pop  (fifo_pop),
        .tx        (tx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    logic [7:0] model_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] src_q[$];

    int checks = 0;
    int passes = 0;
    int pops_acc = 0;
    int pushes_total = 0;
    int frames_checked = 0;
    int collide_cnt = 0;
    int push_pct = 100;
    bit collide_mode = 0;
    bit expect_pop_next = 0;
    bit pend_pop = 0;
    bit pend_push = 0;
    logic [7:0] pend_byte = 8'h00;

    bit mon_active = 0;
    int mon_idx = 0;
    logic bits [0:10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // One clock of the FIFO model plus push stimulus, evaluated mid-cycle.
    task automatic cycle();
        @(negedge clk);
        if (pend_push) model_q.push_back(pend_byte);
        else if (pend_pop && model_q.size() > 0) fifo_data = model_q.pop_front();
        fifo_empty = (model_q.size() == 0);
        if (fifo_pop) check("pop_nonempty", model_q.size() > 0, 1);
        fifo_push = 1'b0;
        if (src_q.size() > 0 && model_q.size() < 4 && (!collide_mode || fifo_pop)
            && $urandom_range(0, 99) < push_pct) begin
            pend_byte = src_q.pop_front();
            fifo_push = 1'b1;
            exp_q.push_back(pend_byte);
            pushes_total++;
            if (fifo_pop) begin
                collide_cnt++;
                expect_pop_next = 1;
            end
        end
        pend_push = fifo_push;
        pend_pop  = fifo_pop && !fifo_push;
        if (pend_pop) pops_acc++;
    endtask

    task automatic wait_src(input int limit);
        int n = 0;
        while (src_q.size() > 0 && n < limit) begin
            cycle();
            n++;
        end
        check("src_drained", src_q.size(), 0);
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while ((src_q.size() > 0 || model_q.size() > 0 || exp_q.size() > 0 || busy) && n < limit) begin
            cycle();
            n++;
        end
        check("drain_exp_empty", exp_q.size(), 0);
        check("drain_not_busy", busy, 0);
    endtask

    // Line decoder and scoreboard consumer.
    initial begin
        int pos;
        int b;
        int gap;
        int collide_snap;
        bit after_frame;
        bit glitch;
        logic [7:0] got;
        logic [7:0] exp_byte;
        gap = 0;
        collide_snap = 0;
        after_frame = 0;
        glitch = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                check("rst_tx", tx, 1);
                check("rst_busy", busy, 0);
                check("rst_pop", fifo_pop, 0);
                check("rst_frame_done", frame_done, 0);
                mon_active = 0;
                after_frame = 0;
                while (frames_checked < pops_acc && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    frames_checked++;
                end
            end else begin
                if (expect_pop_next) begin
                    check("pop_retry", fifo_pop, 1);
                    expect_pop_next = 0;
                end
                if (!mon_active) begin
                    check("frame_done_idle", frame_done, 0);
                    if (tx == 1'b0) begin
                        if (after_frame) check("gap", gap, 2 + collide_cnt - collide_snap);
                        after_frame = 0;
                        mon_active = 1;
                        mon_idx = 0;
                        glitch = 0;
                    end else if (after_frame) begin
                        if (busy) gap++;
                        else after_frame = 0;
                    end
                end
                if (mon_active) begin
                    pos = mon_idx % N;
                    b = mon_idx / N;
                    if (pos == 0) bits[b] = tx;
                    else if (tx != bits[b]) glitch = 1;
                    if (mon_idx == NB * N - 1) begin
                        check("frame_done_end", frame_done, 1);
                        check("start_bit", bits[0], 0);
                        check("stop_bit", bits[NB-1], 1);
                        check("bit_stable", glitch, 0);
                        for (int k = 0; k < 8; k++) got[k] = bits[k+1];
                        if (exp_q.size() > 0) begin
                            exp_byte = exp_q.pop_front();
                            check("byte", got, exp_byte);
`ifdef PARITY_EN
                            check("parity", bits[9], ^exp_byte);
`endif
                        end else begin
                            check("byte_unexpected", exp_q.size(), 1);
                        end
                        frames_checked++;
                        mon_active = 0;
                        after_frame = 1;
                        gap = 0;
                        collide_snap = collide_cnt;
                    end else begin
                        check("frame_done_mid", frame_done, 0);
                    end
                    mon_idx++;
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 5000000", $time);
        $fatal(1);
    end

    initial begin
        bit idle_bad;
        int n;
        reset = 1'b1;
        fifo_push = 1'b0;
        fifo_empty = 1'b1;
        fifo_data = 8'h00;
        repeat (3) cycle();
        reset = 1'b0;

        // Empty FIFO: line must stay quiet.
        idle_bad = 0;
        repeat (100) begin
            cycle();
            if (fifo_pop || busy || !tx) idle_bad = 1;
        end
        check("idle_quiet", idle_bad, 0);

        src_q.push_back(8'hA5);
        wait_drain(2000);

        src_q.push_back(8'h01);
        src_q.push_back(8'h80);
        src_q.push_back(8'hFF);
        wait_drain(2000);

        // Push collides with the first POP cycle.
        src_q.push_back(8'h3C);
        wait_src(50);
        collide_mode = 1;
        src_q.push_back(8'hC3);
        wait_src(50);
        collide_mode = 0;
        wait_drain(2000);

        // Reset while data bit 3 is on the line.
        src_q.push_back(8'h5A);
        n = 0;
        while (!(mon_active && mon_idx >= 4 * N + 1) && n < 500) begin
            cycle();
            n++;
        end
        check("reached_bit3", mon_active && mon_idx >= 4 * N + 1, 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        check("post_rst_idle", busy, 0);
        src_q.push_back(8'hE7);
        wait_drain(2000);

        src_q.push_back(8'h07);
        src_q.push_back(8'h03);
        wait_drain(2000);

        for (int k = 0; k < 8; k++) begin
            push_pct = $urandom_range(5, 100);
            for (int j = 0; j < 5; j++) src_q.push_back(8'($urandom));
            wait_src(3000);
            repeat ($urandom_range(0, 60)) cycle();
        end
        push_pct = 100;
        wait_drain(20000);

        check("pops_vs_pushes", pops_acc, pushes_total);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
